support_idx_regfile: RTL and testbench
======================================

// Module: support_idx_regfile
// PURPOSE
//  Parametrised index register file for the OMP support set: stores atom indices selected per iteration.
//  Adds append (push) with occupancy tracking, two independent read ports, and a registered membership check
//  (duplicate-atom detection) on top of plain addressed write/read. Sits between the argmax stage and LS solver.
// PARAMETERS
//  DATA_W  default `REG_IDX_DATA_WIDTH  width of one stored index
//  DEPTH   default `REG_IDX_SIZE        number of entries (max sparsity K), >=2
//  ADDR_W  default $clog2(DEPTH)        address / position width
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  clr        in   1         sync clear of set (new signal recovery)
//  push       in   1         append push_data at position count
//  push_data  in   DATA_W    index to append
//  wr_en      in   1         overwrite entry wr_addr (must be < count)
//  wr_addr    in   ADDR_W    overwrite address
//  wr_data    in   DATA_W    overwrite data
//  rd_en_a    in   1         read request port A
//  rd_addr_a  in   ADDR_W    read address port A
//  rd_data_a  out  DATA_W    read data A
//  rd_vld_a   out  1         rd_data_a valid (1-cycle pulse)
//  rd_en_b/rd_addr_b/rd_data_b/rd_vld_b  same as A, port B
//  chk_en     in   1         membership check request
//  chk_data   in   DATA_W    index to search
//  chk_hit    out  1         chk_data present in a valid entry
//  chk_pos    out  ADDR_W    lowest matching position (0 if no hit)
//  chk_vld    out  1         chk_hit/chk_pos valid (1-cycle pulse)
//  count      out  ADDR_W+1  number of valid entries, 0..DEPTH
//  full       out  1         count==DEPTH (combinational from count)
//  empty      out  1         count==0 (combinational from count)
//  err        out  1         1-cycle pulse: push while full, or wr_en with wr_addr>=count
// BEHAVIOUR
//  - Reset: all memory entries 0, count 0, all rd_data/rd_vld/chk_*/err outputs 0.
//  - Priority per cycle: clr > (push, wr_en). clr: count<=0, memory zeroed, push/wr ignored, no err.
//  - push && !full: mem[count]<=push_data, count<=count+1. push && full: no change, err=1 next cycle.
//  - wr_en && wr_addr<count: mem[wr_addr]<=wr_data. wr_addr>=count: ignored, err=1 next cycle.
//  - push and legal wr_en in same cycle: both take effect (addresses differ by construction).
//  - count saturates at DEPTH; never wraps. push_addr always = count, no wrap-around.
//  - Reads: latency 1. rd_en at cycle N -> rd_data/rd_vld at N+1. rd_vld low otherwise; rd_data holds.
//  - Read of addr>=count (or >=DEPTH) returns 0 with rd_vld=1.
//  - Read/write same addr same cycle: read-before-write (old data returned). Ports A and B fully independent.
//  - Check: latency 1; compares chk_data against entries 0..count-1 using state BEFORE this cycle's
//    push/wr/clr. chk_pos = lowest matching index via priority encoder; 0 when no hit. count==0 -> hit=0.
//  - Reset mid-operation: all pending read/check results dropped; outputs return to reset values at once.
// STRUCTURE
//  - Shared define file: REG_IDX_DATA_WIDTH, REG_IDX_SIZE defaults; no new typedefs.
//  - Sub-module idx_prio_enc (DEPTH-bit match vector -> ADDR_W position + any flag), combinational.
//  - Storage as flop array (async reset required, no SRAM inference).
// TESTING
//  - Reset then push 5,9,3 -> count=3, empty=0; read A addr1 -> rd_data_a=9, rd_vld_a=1 one cycle later.
//  - Fill DEPTH entries, push again -> err pulse 1 cycle, count stays DEPTH, full=1, contents unchanged.
//  - Set {5,9,3,9}: chk 9 -> hit=1,pos=1; chk 7 -> hit=0,pos=0; chk same cycle as push 7 -> hit=0.
//  - wr_en addr1 data 12 with rd_en_a addr1 same cycle -> rd_data_a=9; next read -> 12; wr addr>=count -> err.
//  - clr with simultaneous push -> count=0, no err, read addr0 -> 0; dual-port reads of addr0/addr2 same cycle correct.
//  - Assert rst mid-push/check -> all outputs 0 immediately, count=0 after release.

Source files
------------

// File: rtl/support_idx_regfile_pkg.sv
// Shared defaults for the OMP support-set index register file.
`ifndef REG_IDX_DATA_WIDTH
`define REG_IDX_DATA_WIDTH 8
`endif
`ifndef REG_IDX_SIZE
`define REG_IDX_SIZE 8
`endif

package support_idx_regfile_pkg;
   localparam int IDX_DATA_W_DEF = `REG_IDX_DATA_WIDTH;
   localparam int IDX_DEPTH_DEF  = `REG_IDX_SIZE;
endpackage

// File: rtl/support_idx_regfile_idx_prio_enc.sv
// Priority encoder: lowest set bit of a match vector -> position, plus any-hit flag.
module idx_prio_enc #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  match_i,
   output logic [ADDR_W-1:0] pos_o,
   output logic              any_o
);

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      pos_o = '0;
      any_o = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_i[i]) begin
            pos_o = ADDR_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/support_idx_regfile.sv
// Support-set index register file: append/overwrite storage, two registered
// read ports and a registered duplicate-atom membership check.
module support_idx_regfile
   import support_idx_regfile_pkg::*;
#(
   parameter int DATA_W = IDX_DATA_W_DEF,
   parameter int DEPTH  = IDX_DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_vld_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_vld_b,
   input  logic              chk_en,
   input  logic [DATA_W-1:0] chk_data,
   output logic              chk_hit,
   output logic [ADDR_W-1:0] chk_pos,
   output logic              chk_vld,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
   logic              rd_vld_a_q, rd_vld_b_q;
   logic              chk_hit_q, chk_hit_d, chk_vld_q;
   logic [ADDR_W-1:0] chk_pos_q, chk_pos_d;

   logic              push_ok, push_bad, wr_ok, wr_bad;
   logic [DEPTH-1:0]  match;
   logic [ADDR_W-1:0] enc_pos;
   logic              enc_any;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // Legality of this cycle's updates; clr masks both the updates and their errors.
   always_comb begin
      push_ok  = push && !full && !clr;
      push_bad = push &&  full && !clr;
      wr_ok    = wr_en && ({1'b0, wr_addr} <  count_q) && !clr;
      wr_bad   = wr_en && ({1'b0, wr_addr} >= count_q) && !clr;
      err_d    = push_bad || wr_bad;
   end

   // Storage and occupancy next state; push and a legal overwrite never collide.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         count_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[count_q[ADDR_W-1:0]] = push_data;
            count_d = count_q + 1'b1;
         end
         if (wr_ok) mem_d[wr_addr] = wr_data;
      end
   end

   // Read ports see pre-update state; unoccupied addresses read as zero.
   always_comb begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      if (rd_en_a) rd_data_a_d = ({1'b0, rd_addr_a} < count_q) ? mem_q[rd_addr_a] : '0;
      if (rd_en_b) rd_data_b_d = ({1'b0, rd_addr_b} < count_q) ? mem_q[rd_addr_b] : '0;
   end

   // Membership match against occupied entries only.
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         match[i] = (CNT_W'(i) < count_q) && (mem_q[i] == chk_data);
   end

   idx_prio_enc #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prio_enc (
      .match_i (match),
      .pos_o   (enc_pos),
      .any_o   (enc_any)
   );

   // Check results hold between requests, like the read data.
   always_comb begin
      chk_hit_d = chk_en ? enc_any : chk_hit_q;
      chk_pos_d = chk_en ? enc_pos : chk_pos_q;
   end

   // State registers; reset drops any pending read/check result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q       <= '{default: '0};
         count_q     <= '0;
         err_q       <= 1'b0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_vld_a_q  <= 1'b0;
         rd_vld_b_q  <= 1'b0;
         chk_hit_q   <= 1'b0;
         chk_pos_q   <= '0;
         chk_vld_q   <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         count_q     <= count_d;
         err_q       <= err_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_vld_a_q  <= rd_en_a;
         rd_vld_b_q  <= rd_en_b;
         chk_hit_q   <= chk_hit_d;
         chk_pos_q   <= chk_pos_d;
         chk_vld_q   <= chk_en;
      end
   end

   assign count     = count_q;
   assign err       = err_q;
   assign rd_data_a = rd_data_a_q;
   assign rd_vld_a  = rd_vld_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_vld_b  = rd_vld_b_q;
   assign chk_hit   = chk_hit_q;
   assign chk_pos   = chk_pos_q;
   assign chk_vld   = chk_vld_q;

endmodule

// File: tb/tb_support_idx_regfile.sv
// Directed vector bench for support_idx_regfile at default parameters (8-bit data, 8 entries).
module tb_support_idx_regfile;
   import support_idx_regfile_pkg::*;

   localparam int DW = IDX_DATA_W_DEF;
   localparam int DP = IDX_DEPTH_DEF;
   localparam int AW = $clog2(DP);

   logic          clk = 1'b0;
   logic          rst;
   logic          clr, push, wr_en, rd_en_a, rd_en_b, chk_en;
   logic [DW-1:0] push_data, wr_data, chk_data;
   logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          rd_vld_a, rd_vld_b, chk_hit, chk_vld, full, empty, err;
   logic [AW-1:0] chk_pos;
   logic [AW:0]   count;

   int n_vec = 0;
   int n_bad = 0;
   int last_a = 0;
   int last_b = 0;

   always #5 clk = ~clk;

   support_idx_regfile dut (
      .clk(clk), .rst(rst), .clr(clr), .push(push), .push_data(push_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_vld_a(rd_vld_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_vld_b(rd_vld_b),
      .chk_en(chk_en), .chk_data(chk_data), .chk_hit(chk_hit), .chk_pos(chk_pos), .chk_vld(chk_vld),
      .count(count), .full(full), .empty(empty), .err(err)
   );

   typedef struct {
      int clr, push, pd, wr, wa, wd, ra, aa, rb, ab, ck, cd;
      int e_cnt, e_err, e_da, e_db, e_hit, e_pos;
   } vec_t;

   vec_t vecs [27];

   task automatic cmp(input string nm, input int act, input int exp);
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      clr = 0; push = 0; push_data = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
      rd_en_a = 0; rd_addr_a = '0; rd_en_b = 0; rd_addr_b = '0; chk_en = 0; chk_data = '0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string t;
      @(negedge clk);
      clr = 1'(v.clr); push = 1'(v.push); push_data = DW'(v.pd);
      wr_en = 1'(v.wr); wr_addr = AW'(v.wa); wr_data = DW'(v.wd);
      rd_en_a = 1'(v.ra); rd_addr_a = AW'(v.aa); rd_en_b = 1'(v.rb); rd_addr_b = AW'(v.ab);
      chk_en = 1'(v.ck); chk_data = DW'(v.cd);
      @(posedge clk);
      #1;
      n_vec++;
      t = $sformatf("v%0d", idx);
      cmp({t, " count"}, int'(count), v.e_cnt);
      cmp({t, " full"},  int'(full),  (v.e_cnt == DP) ? 1 : 0);
      cmp({t, " empty"}, int'(empty), (v.e_cnt == 0) ? 1 : 0);
      cmp({t, " err"},   int'(err),   v.e_err);
      cmp({t, " rd_vld_a"}, int'(rd_vld_a), v.ra);
      cmp({t, " rd_vld_b"}, int'(rd_vld_b), v.rb);
      cmp({t, " chk_vld"},  int'(chk_vld),  v.ck);
      if (v.ra != 0) last_a = v.e_da;
      if (v.rb != 0) last_b = v.e_db;
      cmp({t, " rd_data_a"}, int'(rd_data_a), last_a);
      cmp({t, " rd_data_b"}, int'(rd_data_b), last_b);
      if (v.ck != 0) begin
         cmp({t, " chk_hit"}, int'(chk_hit), v.e_hit);
         cmp({t, " chk_pos"}, int'(chk_pos), v.e_pos);
      end
   endtask

   initial begin
      // clr push pd wr wa wd ra aa rb ab ck cd | cnt err da db hit pos
      vecs[0]  = '{0,1, 5,0,0, 0,0,0,0,0,0, 0,  1,0, 0,0,0,0};
      vecs[1]  = '{0,1, 9,0,0, 0,0,0,0,0,0, 0,  2,0, 0,0,0,0};
      vecs[2]  = '{0,1, 3,0,0, 0,0,0,0,0,0, 0,  3,0, 0,0,0,0};
      vecs[3]  = '{0,0, 0,0,0, 0,1,1,0,0,0, 0,  3,0, 9,0,0,0};
      vecs[4]  = '{0,1, 9,0,0, 0,0,0,0,0,1, 9,  4,0, 0,0,1,1};
      vecs[5]  = '{0,0, 0,0,0, 0,0,0,0,0,1, 7,  4,0, 0,0,0,0};
      vecs[6]  = '{0,1, 7,0,0, 0,0,0,0,0,1, 7,  5,0, 0,0,0,0};
      vecs[7]  = '{0,0, 0,0,0, 0,0,0,0,0,1, 7,  5,0, 0,0,1,4};
      vecs[8]  = '{0,0, 0,1,1,12,1,1,0,0,0, 0,  5,0, 9,0,0,0};
      vecs[9]  = '{0,0, 0,0,0, 0,1,1,1,2,0, 0,  5,0,12,3,0,0};
      vecs[10] = '{0,0, 0,1,5,44,0,0,0,0,0, 0,  5,1, 0,0,0,0};
      vecs[11] = '{0,0, 0,0,0, 0,1,5,0,0,0, 0,  5,0, 0,0,0,0};
      vecs[12] = '{0,1,20,0,0, 0,0,0,0,0,0, 0,  6,0, 0,0,0,0};
      vecs[13] = '{0,1,21,0,0, 0,0,0,0,0,0, 0,  7,0, 0,0,0,0};
      vecs[14] = '{0,1,22,0,0, 0,0,0,0,0,0, 0,  8,0, 0,0,0,0};
      vecs[15] = '{0,1,99,0,0, 0,0,0,0,0,0, 0,  8,1, 0,0,0,0};
      vecs[16] = '{0,0, 0,0,0, 0,1,7,1,0,0, 0,  8,0,22,5,0,0};
      vecs[17] = '{0,0, 0,0,0, 0,0,0,0,0,1,99,  8,0, 0,0,0,0};
      vecs[18] = '{0,0, 0,0,0, 0,0,0,0,0,1, 9,  8,0, 0,0,1,3};
      vecs[19] = '{1,1,50,0,0, 0,0,0,0,0,0, 0,  0,0, 0,0,0,0};
      vecs[20] = '{0,0, 0,0,0, 0,1,0,1,2,1, 5,  0,0, 0,0,0,0};
      vecs[21] = '{0,1, 6,0,0, 0,1,0,0,0,0, 0,  1,0, 0,0,0,0};
      vecs[22] = '{0,0, 0,0,0, 0,1,0,1,0,0, 0,  1,0, 6,6,0,0};
      vecs[23] = '{0,1, 8,1,0, 4,0,0,0,0,0, 0,  2,0, 0,0,0,0};
      vecs[24] = '{0,0, 0,0,0, 0,1,0,1,1,0, 0,  2,0, 4,8,0,0};
      vecs[25] = '{0,0, 0,1,2,77,0,0,0,0,0, 0,  2,1, 0,0,0,0};
      vecs[26] = '{1,0, 0,1,0, 1,0,0,0,0,0, 0,  0,0, 0,0,0,0};

      idle_inputs();
      rst = 1'b1;
      #2;
      n_vec++;
      cmp("reset count", int'(count), 0);
      cmp("reset empty", int'(empty), 1);
      cmp("reset full",  int'(full),  0);
      cmp("reset err",   int'(err),   0);
      cmp("reset outs",  int'({rd_vld_a, rd_vld_b, chk_vld, chk_hit}), 0);
      cmp("reset rd_data", int'(rd_data_a) + int'(rd_data_b) + int'(chk_pos), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 27; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a push/read/check burst.
      @(negedge clk); idle_inputs(); push = 1; push_data = 8'd1;
      @(negedge clk); push_data = 8'd2;
      @(negedge clk); push_data = 8'd3; rd_en_a = 1; rd_addr_a = 1; chk_en = 1; chk_data = 8'd2;
      @(posedge clk); #1;
      n_vec++;
      cmp("pre-rst count", int'(count), 3);
      cmp("pre-rst rd_data_a", int'(rd_data_a), 2);
      cmp("pre-rst rd_vld_a", int'(rd_vld_a), 1);
      cmp("pre-rst chk_hit", int'(chk_hit), 1);
      cmp("pre-rst chk_pos", int'(chk_pos), 1);
      push_data = 8'd4;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      cmp("mid-rst count", int'(count), 0);
      cmp("mid-rst rd_data_a", int'(rd_data_a), 0);
      cmp("mid-rst rd_vld_a", int'(rd_vld_a), 0);
      cmp("mid-rst chk", int'({chk_vld, chk_hit}), 0);
      cmp("mid-rst chk_pos", int'(chk_pos), 0);
      cmp("mid-rst empty", int'(empty), 1);
      @(negedge clk); idle_inputs(); rst = 1'b0;
      @(negedge clk); rd_en_a = 1; rd_addr_a = 0;
      @(posedge clk); #1;
      n_vec++;
      cmp("post-rst count", int'(count), 0);
      cmp("post-rst rd_vld_a", int'(rd_vld_a), 1);
      cmp("post-rst rd_data_a", int'(rd_data_a), 0);
      cmp("post-rst err", int'(err), 0);
      @(negedge clk); idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
